mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit sitting directly downstream of the register unit.
//  Consumes the rs1/rs2 read data and returns the result plus a destination tag.
//  The tag and done strobe drive the register unit write port (DataWr/RUWr/rd) on completion.
//  It uses a shift-add multiplier and a restoring divider, one bit per cycle, with a start/busy/done handshake.
// PARAMETERS
//  XLEN  32  operand/result width; the iteration count equals XLEN
// PORTS
//  clk       in   1     clock, all state updates on posedge
//  rst_n     in   1     asynchronous active-low reset
//  start     in   1     request; sampled only when busy=0
//  funct3    in   3     RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  rs1_data  in   XLEN  operand A (dividend / multiplicand)
//  rs2_data  in   XLEN  operand B (divisor / multiplier)
//  rd_in     in   5     destination register tag
//  busy      out  1     operation in flight; new start ignored
//  done      out  1     one-cycle pulse; result/rd_out valid; connect to RUWr
//  result    out  XLEN  result, held stable until next accepted start
//  rd_out    out  5     latched rd_in, held with result
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=0, rd_out=0, internal regs=0.
//  FSM states:
//   IDLE: start=1 latches funct3, rd_in, operands and operand signs.
//     Special case? -> DONE. Otherwise -> CALC, count=0.
//   CALC: one iteration per cycle; count increments; after count==XLEN-1 -> SIGN.
//   SIGN: apply sign correction and select hi/lo or quotient/remainder into result -> DONE.
//   DONE: done=1 for exactly one cycle -> IDLE.
//  busy=1 in CALC, SIGN and DONE; busy=0 in IDLE.
//  Latency (normal): start sampled at edge E0; done high in the cycle after edge E0+XLEN+1.
//   That is XLEN+2 cycles; with XLEN=32, done is high 34 cycles after start.
//  Latency (special case): done high in the cycle after E0, i.e. 1 cycle.
//  Multiply: operands are taken as magnitudes per signedness.
//   MUL/MULH: both signed. MULHSU: A signed, B unsigned. MULHU: both unsigned.
//   Product is 2*XLEN bits; the result is negated in SIGN when the operand signs differ.
//   MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
//  Divide: restoring algorithm on magnitudes.
//   Quotient is negated if signs differ (signed ops).
//   Remainder takes the sign of the dividend.
//  Special cases (RISC-V defined, no trap):
//   Divisor==0: DIV/DIVU -> all ones; REM/REMU -> rs1_data.
//   Signed overflow (A=-2^(XLEN-1), B=-1): DIV -> -2^(XLEN-1); REM -> 0.
//   Either multiply operand==0 -> result 0 via the special path.
//  start while busy=1 is ignored entirely; latched operands and rd are not disturbed.
//  start in the DONE cycle is ignored; start in the IDLE cycle right after done is accepted.
//  Input operands may change after the start cycle without effect.
//  rd_in==0 is carried normally; the register unit discards x0 writes.
//  Asserting rst_n mid-operation aborts immediately: no done pulse, outputs return to reset values.
// TESTING
//  MUL 7*6, rd=5 -> done pulse exactly 34 cycles after start; result=42; rd_out=5; busy low next cycle.
//  MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1*2 -> 0xFFFFFFFF.
//  DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, REM -> 0; each done after 1 cycle.
//  Second start pulsed with different operands at cycle 10 of a DIV -> ignored; original result and rd_out kept.
//  rst_n dropped at cycle 20 of a MUL -> busy=0, result=0 asynchronously; no done; next op completes normally.

Source files
------------

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M multiply/divide unit
//
// Purpose: shift-add multiplier and restoring divider, one bit per cycle,
// sitting after the register unit. Result and rd tag feed the register
// write port; done is the write strobe.
//
// Ports:
//   clk, rst_n            clock (posedge), asynchronous active-low reset
//   start                 request, sampled only while busy=0
//   funct3                RV32M op select (MUL..REMU)
//   rs1_data, rs2_data    operand A (dividend/multiplicand), operand B
//   rd_in                 destination tag, latched with the operands
//   busy                  operation in flight (CALC, SIGN, DONE)
//   done                  one-cycle completion pulse
//   result, rd_out        held until the next accepted start
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_t;

  state_t state_q, state_d;

  // hi_q/lo_q hold the running product for multiplies and the
  // remainder/quotient pair for divides; m_q is the multiplicand or divisor.
  logic [XLEN-1:0] hi_q, lo_q, m_q;
  logic [CW-1:0]   count_q;
  logic            is_div_q, neg_q, sel_hi_q;

  // Request decode, evaluated on the raw inputs in IDLE.
  logic            is_div_in, a_sgn_in, b_sgn_in, a_neg_in, b_neg_in;
  logic            neg_in, sel_hi_in;
  logic [XLEN-1:0] a_mag_in, b_mag_in;
  logic            div_zero, div_ovf, mul_zero, special;
  logic [XLEN-1:0] special_val;

  always_comb begin
    is_div_in = funct3[2];
    a_sgn_in  = is_div_in ? ~funct3[0] : (funct3[1:0] != 2'b11);
    b_sgn_in  = is_div_in ? ~funct3[0] : ~funct3[1];
    a_neg_in  = a_sgn_in & rs1_data[XLEN-1];
    b_neg_in  = b_sgn_in & rs2_data[XLEN-1];
    a_mag_in  = a_neg_in ? -rs1_data : rs1_data;
    b_mag_in  = b_neg_in ? -rs2_data : rs2_data;
    // Remainder follows the dividend sign; everything else follows sign xor.
    neg_in    = (is_div_in & funct3[1]) ? a_neg_in : (a_neg_in ^ b_neg_in);
    // High half for MULH*, remainder for REM*.
    sel_hi_in = is_div_in ? funct3[1] : (funct3[1:0] != 2'b00);

    div_zero  = is_div_in & (rs2_data == '0);
    div_ovf   = is_div_in & ~funct3[0] &
                (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_data == '1);
    mul_zero  = ~is_div_in & ((rs1_data == '0) | (rs2_data == '0));
    special   = div_zero | div_ovf | mul_zero;

    special_val = '0;
    if (div_zero)
      special_val = funct3[1] ? rs1_data : '1;
    else if (div_ovf)
      special_val = funct3[1] ? '0 : rs1_data;
  end

  // One iteration step.
  logic [XLEN:0]   mul_sum, div_tmp, div_diff;
  logic [XLEN-1:0] hi_n, lo_n;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    div_tmp  = {hi_q, lo_q[XLEN-1]};
    div_diff = div_tmp - {1'b0, m_q};
    if (is_div_q) begin
      // Partial remainder stays below the divisor, so the top bit of the
      // difference is a pure borrow flag.
      if (!div_diff[XLEN]) begin
        hi_n = div_diff[XLEN-1:0];
        lo_n = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_n = div_tmp[XLEN-1:0];
        lo_n = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign correction and result selection.
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   res_hi, res_lo, final_val;

  always_comb begin
    prod_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    if (is_div_q) begin
      res_hi = neg_q ? -hi_q : hi_q;
      res_lo = neg_q ? -lo_q : lo_q;
    end else begin
      res_hi = prod_s[2*XLEN-1:XLEN];
      res_lo = prod_s[XLEN-1:0];
    end
    final_val = sel_hi_q ? res_hi : res_lo;
  end

  // FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = special ? S_DONE : S_CALC;
      S_CALC: if (count_q == CW'(XLEN-1)) state_d = S_SIGN;
      S_SIGN: state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      count_q  <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      sel_hi_q <= 1'b0;
      result   <= '0;
      rd_out   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rd_out   <= rd_in;
            count_q  <= '0;
            is_div_q <= is_div_in;
            neg_q    <= neg_in;
            sel_hi_q <= sel_hi_in;
            if (special) begin
              result <= special_val;
            end else begin
              hi_q <= '0;
              lo_q <= is_div_in ? a_mag_in : b_mag_in;
              m_q  <= is_div_in ? b_mag_in : a_mag_in;
            end
          end
        end
        S_CALC: begin
          hi_q    <= hi_n;
          lo_q    <= lo_n;
          count_q <= count_q + 1'b1;
        end
        S_SIGN: result <= final_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_in;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    funct3 = f; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
  endtask

  // Called right after launch at a negedge; returns at the negedge where
  // done is high (or the budget ran out). lat counts edges from E0.
  task automatic wait_done(output int lat);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rs1_data = ~rs1_data; rs2_data = ~rs2_data; rd_in = ~rd_in;
    lat = 1;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic seen_done;

    vecs[0]  = '{3'b000, 32'd7,        32'd6,        5'd5,  32'd42,       34};
    vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000, 34};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 34};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF, 34};
    vecs[4]  = '{3'b000, 32'hFFFFFFFD, 32'd5,        5'd0,  32'hFFFFFFF1, 34};
    vecs[5]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'h00000000, 34};
    vecs[6]  = '{3'b011, 32'h80000000, 32'd2,        5'd6,  32'h00000001, 34};
    vecs[7]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, 34};
    vecs[8]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 34};
    vecs[9]  = '{3'b101, 32'd100,      32'd7,        5'd9,  32'd14,       34};
    vecs[10] = '{3'b111, 32'd100,      32'd7,        5'd10, 32'd2,        34};
    vecs[11] = '{3'b100, 32'd7,        32'hFFFFFFFE, 5'd11, 32'hFFFFFFFD, 34};
    vecs[12] = '{3'b110, 32'd7,        32'hFFFFFFFE, 5'd12, 32'd1,        34};
    vecs[13] = '{3'b100, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1};
    vecs[14] = '{3'b111, 32'd5,        32'd0,        5'd14, 32'd5,        1};
    vecs[15] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1};
    vecs[16] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h00000000, 1};
    vecs[17] = '{3'b000, 32'd0,        32'd123,      5'd17, 32'h00000000, 1};
    vecs[18] = '{3'b011, 32'h12345678, 32'd0,        5'd18, 32'h00000000, 1};
    vecs[19] = '{3'b101, 32'hFFFFFFFF, 32'd1,        5'd19, 32'hFFFFFFFF, 34};
    vecs[20] = '{3'b010, 32'd2,        32'hFFFFFFFF, 5'd20, 32'h00000001, 34};
    vecs[21] = '{3'b110, 32'hFFFFFFF9, 32'd0,        5'd31, 32'hFFFFFFF9, 1};

    rst_n = 1'b0; start = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0; rd_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy",   {31'b0, busy},   32'd0);
    chk("reset_done",   {31'b0, done},   32'd0);
    chk("reset_result", result,          32'd0);
    chk("reset_rd",     {27'b0, rd_out}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      launch(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd);
      wait_done(lat);
      chk($sformatf("vec%0d_result", i), result, vecs[i].exp);
      chk($sformatf("vec%0d_rd", i), {27'b0, rd_out}, {27'b0, vecs[i].rd});
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      @(negedge clk);
      chk($sformatf("vec%0d_after_done", i), {30'b0, done, busy}, 32'd0);
    end

    // Start pulsed mid-divide with a divide-by-zero request: must be ignored.
    @(negedge clk);
    launch(3'b101, 32'd100, 32'd7, 5'd9);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; rs1_data = 32'd0; rs2_data = 32'd0;
    lat = 1;
    while (!done && lat < 200) begin
      if (lat == 10) launch(3'b100, 32'd5, 32'd0, 5'd3);
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk("busy_start_result", result, 32'd14);
    chk("busy_start_rd", {27'b0, rd_out}, 32'd9);
    chk("busy_start_latency", 32'(lat), 32'd34);

    // Start during the done cycle is ignored.
    launch(3'b100, 32'd5, 32'd0, 5'd3);
    @(negedge clk);
    start = 1'b0;
    chk("done_cycle_start_busy", {30'b0, done, busy}, 32'd0);
    chk("done_cycle_start_result", result, 32'd14);
    chk("done_cycle_start_rd", {27'b0, rd_out}, 32'd9);

    // Start in the IDLE cycle right after done is accepted.
    launch(3'b000, 32'd7, 32'd6, 5'd5);
    wait_done(lat);
    chk("idle_after_done_result", result, 32'd42);
    chk("idle_after_done_rd", {27'b0, rd_out}, 32'd5);
    chk("idle_after_done_latency", 32'(lat), 32'd34);

    // Reset mid-multiply.
    @(negedge clk);
    launch(3'b000, 32'd11, 32'd13, 5'd22);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("pre_reset_busy", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_busy",   {31'b0, busy},   32'd0);
    chk("async_reset_done",   {31'b0, done},   32'd0);
    chk("async_reset_result", result,          32'd0);
    chk("async_reset_rd",     {27'b0, rd_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen_done = seen_done | done;
    end
    chk("no_done_after_reset", {31'b0, seen_done}, 32'd0);

    @(negedge clk);
    launch(3'b000, 32'd9, 32'd9, 5'd21);
    wait_done(lat);
    chk("post_reset_result", result, 32'd81);
    chk("post_reset_rd", {27'b0, rd_out}, 32'd21);
    chk("post_reset_latency", 32'(lat), 32'd34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
